// File: rtl/operand_flit_injector_pkg.sv
// Shared FSM encoding and counter widths for the operand flit injector.
// Latency/backpressure: none, types and helpers only.
package operand_flit_injector_pkg;

    localparam int STATE_W      = 2;
    localparam int TOGGLE_CNT_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [TOGGLE_CNT_W-1:0] sat_add(
        input logic [TOGGLE_CNT_W-1:0] a,
        input logic [TOGGLE_CNT_W-1:0] b
    );
        logic [TOGGLE_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[TOGGLE_CNT_W] ? {TOGGLE_CNT_W{1'b1}} : sum[TOGGLE_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/operand_flit_injector_thermo_pattern_gen.sv
// Registered thermometer flit: lower/upper `ones` bits set, alternating side on each advance.
// Latency: flit updates the cycle after pat_reset/advance; holds otherwise (no backpressure of its own).
module thermo_pattern_gen #(
    parameter int W      = 60,
    parameter int STRIDE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pat_reset,
    input  logic         advance,
    output logic [W-1:0] flit
);

    localparam int OW  = $clog2(W + 1);
    localparam int OW1 = OW + 1;
    localparam logic [OW:0] STEP     = OW1'(STRIDE);
    localparam logic [OW:0] WRAP_AT  = OW1'(W);
    localparam logic [OW:0] WRAP_SUB = OW1'(W + 1);

    logic [OW-1:0] ones;
    logic          hi;
    logic [OW:0]   ones_sum;
    logic [OW-1:0] ones_next;
    logic          hi_next;

    function automatic logic [W-1:0] thermo(input logic [OW-1:0] cnt, input logic upper);
        return upper ? ~({W{1'b1}} >> cnt) : ~({W{1'b1}} << cnt);
    endfunction

    // Wrapping one past W keeps the ones-count sequence from locking onto a short cycle.
    always_comb begin
        ones_sum  = {1'b0, ones} + STEP;
        ones_next = ones_sum[OW-1:0];
        if (ones_sum > WRAP_AT) begin
            ones_next = OW'(ones_sum - WRAP_SUB);
        end
        hi_next = ~hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            hi   <= 1'b0;
            flit <= '0;
        end else if (pat_reset) begin
            ones <= '0;
            hi   <= 1'b0;
            flit <= '0;
        end else if (advance) begin
            ones <= ones_next;
            hi   <= hi_next;
            flit <= thermo(ones_next, hi_next);
        end
    end

endmodule

// File: rtl/operand_flit_injector.sv
// Packetised thermometer-pattern operand source for adder energy characterization; TOGGLE_CNT_EN adds toggle_cnt.
// Latency: start -> flit 0 valid next cycle; backpressure: out_ready low holds op_a/op_b, no flit dropped or repeated.
module operand_flit_injector
    import operand_flit_injector_pkg::*;
#(
    parameter int N        = 30,
    parameter int PAYLOAD  = 20,
    parameter int GAP      = 7,
    parameter int NUM_PKTS = 10,
    parameter int STRIDE   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            op_a,
    output logic [N-1:0]            op_b,
    output logic                    busy,
    output logic                    done,
`ifdef TOGGLE_CNT_EN
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt,
`endif
    output logic [15:0]             pkt_cnt
);

    localparam int W       = 2 * N;
    localparam int FLIT_CW = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int GAP_CW  = (GAP > 1) ? $clog2(GAP) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [FLIT_CW-1:0]   flit_cnt;
    logic [GAP_CW-1:0]    gap_cnt;
    logic [W-1:0]         flit;
    logic                 hs;
    logic                 last_flit;
    logic                 last_pkt;
    logic                 gap_end;
    logic                 pat_reset;
    logic                 pat_adv;
    logic                 run_clr;

    assign out_valid = (state == ST_SEND);
    assign busy      = (state == ST_SEND) || (state == ST_GAP);
    assign done      = (state == ST_DONE);
    assign hs        = out_valid && out_ready;
    assign last_flit = (flit_cnt == FLIT_CW'(PAYLOAD - 1));
    assign last_pkt  = (pkt_cnt == 16'(NUM_PKTS - 1));
    assign gap_end   = (gap_cnt == GAP_CW'(GAP - 1));
    assign op_a      = flit[N-1:0];
    assign op_b      = flit[W-1:N];

    thermo_pattern_gen #(
        .W      (W),
        .STRIDE (STRIDE)
    ) u_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .pat_reset (pat_reset),
        .advance   (pat_adv),
        .flit      (flit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last flit of a packet does not advance the pattern, so op_a/op_b hold through GAP/DONE.
    always_comb begin
        state_nxt = state;
        pat_reset = 1'b0;
        pat_adv   = 1'b0;
        run_clr   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SEND;
                    pat_reset = 1'b1;
                    run_clr   = 1'b1;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (!last_flit) begin
                        pat_adv = 1'b1;
                    end else if (last_pkt) begin
                        state_nxt = ST_DONE;
                    end else if (GAP > 0) begin
                        state_nxt = ST_GAP;
                    end else begin
                        pat_reset = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_nxt = ST_SEND;
                    pat_reset = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            if (run_clr) begin
                flit_cnt <= '0;
                pkt_cnt  <= '0;
            end else if (hs) begin
                if (last_flit) begin
                    flit_cnt <= '0;
                    pkt_cnt  <= pkt_cnt + 16'd1;
                end else begin
                    flit_cnt <= flit_cnt + 1'b1;
                end
            end
            if ((state == ST_GAP) && !gap_end) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

`ifdef TOGGLE_CNT_EN
    logic [W-1:0]            last_acc;
    logic [W-1:0]            diff;
    logic [TOGGLE_CNT_W-1:0] flips;

    always_comb begin
        diff  = flit ^ last_acc;
        flips = '0;
        for (int i = 0; i < W; i++) begin
            flips = flips + TOGGLE_CNT_W'(diff[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_acc   <= '0;
            toggle_cnt <= '0;
        end else if (run_clr) begin
            last_acc   <= '0;
            toggle_cnt <= '0;
        end else if (hs) begin
            last_acc   <= flit;
            toggle_cnt <= sat_add(toggle_cnt, flips);
        end
    end
`endif

endmodule

// File: tb/tb_operand_flit_injector.sv
// Scoreboard bench: expected flits queued when a start is honoured, popped on every accepted flit.
module tb_operand_flit_injector;

    localparam int N   = 30;
    localparam int W   = 60;
    localparam int PAY = 20;
    localparam int NP  = 10;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready, start2, out_ready2;
    logic        out_valid, busy, done, v2, busy2, done2;
    logic [N-1:0] op_a, op_b, a2, b2;
    logic [15:0] pkt_cnt, pk2;
`ifdef TOGGLE_CNT_EN
    logic [31:0] toggle_cnt, toggle2;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit rand_mode = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];
    logic [W-1:0] first_pkt[0:PAY-1];
    int  run_hs = 0, busy_cyc = 0, valid_cyc = 0;
    int  busy2_cyc = 0, valid2_cyc = 0;
    bit  prev_stall = 0, prev_done = 0, prev_hs = 0;
    logic [W-1:0] prev_flit = '0;

    always #5 clk = ~clk;

    operand_flit_injector dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
`ifdef TOGGLE_CNT_EN
        .toggle_cnt(toggle_cnt),
`endif
        .pkt_cnt(pkt_cnt)
    );

    operand_flit_injector #(.N(30), .PAYLOAD(3), .GAP(0), .NUM_PKTS(2), .STRIDE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .out_valid(v2), .out_ready(out_ready2),
        .op_a(a2), .op_b(b2), .busy(busy2), .done(done2),
`ifdef TOGGLE_CNT_EN
        .toggle_cnt(toggle2),
`endif
        .pkt_cnt(pk2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Flit k of a packet, built bit by bit from the ones/hi walk.
    function automatic logic [W-1:0] model_flit(input int k);
        int ones = 0;
        bit hi = 0;
        logic [W-1:0] f;
        for (int i = 0; i < k; i++) begin
            hi = !hi;
            ones += 4;
            if (ones > W) ones -= W + 1;
        end
        for (int b = 0; b < W; b++) f[b] = hi ? (b >= W - ones) : (b < ones);
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 0;
            prev_done  = 0;
            prev_hs    = 0;
        end else begin
            if (start && !busy) begin
                exp_q.delete();
                run_hs = 0; busy_cyc = 0; valid_cyc = 0;
                for (int p = 0; p < NP; p++)
                    for (int k = 0; k < PAY; k++) exp_q.push_back(model_flit(k));
            end
            if (busy) busy_cyc++;
            if (out_valid) valid_cyc++;
            if (prev_stall && out_valid) chk("stall_hold", {op_b, op_a}, prev_flit);
            if (done && !prev_done) begin
                chk("done_hs_count", run_hs, NP * PAY);
                chk("done_after_hs", prev_hs, 1);
            end
            if (out_valid && out_ready) begin
`ifdef TOGGLE_CNT_EN
                if (run_hs == 0) chk("toggle_clear", toggle_cnt, 0);
                if (run_hs == 3) chk("toggle_3hs", toggle_cnt, 16);
`endif
                chk("pkt_cnt_live", pkt_cnt, run_hs / PAY);
                if (exp_q.size() == 0) chk("unexpected_flit", 1, 0);
                else chk("flit", {op_b, op_a}, exp_q.pop_front());
                if (run_hs < PAY) first_pkt[run_hs] = {op_b, op_a};
                run_hs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = {op_b, op_a};
            prev_done  = done;
            prev_hs    = out_valid && out_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp2_q.delete();
        end else begin
            if (start2 && !busy2) begin
                exp2_q.delete();
                busy2_cyc = 0; valid2_cyc = 0;
                for (int p = 0; p < 2; p++)
                    for (int k = 0; k < 3; k++) exp2_q.push_back(model_flit(k));
            end
            if (busy2) busy2_cyc++;
            if (v2) valid2_cyc++;
            if (v2 && out_ready2) begin
                if (exp2_q.size() == 0) chk("gap0_unexpected", 1, 0);
                else chk("gap0_flit", {b2, a2}, exp2_q.pop_front());
            end
        end
    end

    task automatic pulse(input bit second);
        @(posedge clk); #1;
        if (second) start2 = 1; else start = 1;
        @(posedge clk); #1;
        start = 0; start2 = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk(tag, done, 1);
        out_ready = 1;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (run_hs < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_hs_reached", run_hs >= target, 1);
    endtask

    task automatic check_literals(input string tag);
        logic [W-1:0] f;
        f = first_pkt[0];  chk({tag, "_f0"}, f, 0);
        f = first_pkt[1];  chk({tag, "_f1"}, f, {30'h3C000000, 30'h0});
        f = first_pkt[2];  chk({tag, "_f2"}, f, {30'h0, 30'h000000FF});
        f = first_pkt[3];  chk({tag, "_f3"}, f, {30'h3FFC0000, 30'h0});
        f = first_pkt[15]; chk({tag, "_f15"}, f, {30'h3FFFFFFF, 30'h3FFFFFFF});
        f = first_pkt[16]; chk({tag, "_f16"}, f, {30'h0, 30'h7});
    endtask

    initial begin
        rst_n = 0; start = 0; out_ready = 1; start2 = 0; out_ready2 = 1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ops", {op_b, op_a}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("idle_no_valid", out_valid, 0);

        // Run 1: no backpressure, with a start while busy that must be ignored.
        pulse(0);
        wait_hs(30);
        pulse(0);
        wait_done(2000, "run1_done");
        chk("run1_pkt_cnt", pkt_cnt, NP);
        chk("run1_busy_cycles", busy_cyc, 200 + 9 * 7);
        chk("run1_valid_cycles", valid_cyc, 200);
        chk("run1_queue_empty", exp_q.size(), 0);
        check_literals("run1");
        @(negedge clk);
        chk("done_holds", {done, out_valid, busy}, 3'b100);

        // Run 2: random backpressure, same accepted sequence.
        rand_mode = 1;
        pulse(0);
        wait_done(5000, "run2_done");
        rand_mode = 0;
        chk("run2_pkt_cnt", pkt_cnt, NP);
        chk("run2_queue_empty", exp_q.size(), 0);
        check_literals("run2");

        // Asynchronous reset in the middle of flit 7.
        pulse(0);
        wait_hs(7);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ops", {op_b, op_a}, 0);
        chk("arst_busy_done", {busy, done}, 0);
        chk("arst_pkt_cnt", pkt_cnt, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", out_valid, 0);
        pulse(0);
        wait_done(2000, "run3_done");
        chk("run3_pkt_cnt", pkt_cnt, NP);
        chk("run3_queue_empty", exp_q.size(), 0);

        // Back-to-back packets with GAP=0.
        pulse(1);
        begin
            int n = 0;
            while (!done2 && n < 100) begin @(posedge clk); #1; n++; end
        end
        chk("gap0_done", done2, 1);
        chk("gap0_pkt_cnt", pk2, 2);
        chk("gap0_valid_cycles", valid2_cyc, 6);
        chk("gap0_busy_cycles", busy2_cyc, 6);
        chk("gap0_queue_empty", exp2_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
